alu_op_sequencer: RTL and testbench

- Initiator/driver side of the 64-bit ALU operand interface: accepts operation requests over a valid/ready handshake, drives `first_input`/`second_input`/`alu_control` into the combinational ALU, and captures `alu_result`/`zero`.
- Returns the captured result over a valid/ready response channel.
- Sits between the control path (or a bench/host) and the `alu` instance, so the ALU is only ever driven by registered operands.

---
 rtl/alu_op_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Drives a combinational ALU from registered operands. A request is taken over
// a valid/ready handshake, the ALU gets one cycle to settle, and the captured
// result is returned over a valid/ready response channel.
//
// Optional build macro: ALU_SEQ_SELF_CHECK_EN
//   defined   - reference model compares the ALU result/zero for defined ops
//               and sets a sticky chk_err on mismatch
//   undefined - chk_err is tied low
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake
//   req_a, req_b, req_op            request operands and control code
//   first_input, second_input,
//   alu_control                     registered ALU drive
//   alu_result, zero                ALU outputs
//   rsp_valid/rsp_ready             response handshake
//   rsp_result, rsp_zero,
//   rsp_illegal                     captured response
//   busy                            not in IDLE
//   chk_err                         sticky self-check mismatch
//
// state  | meaning
// IDLE   | ready for a request, ALU ports hold last operands
// SETTLE | operands applied, ALU settling, result captured at end
// RESP   | response valid, waiting for rsp_ready

module alu_op_sequencer #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [CTRL_W-1:0] req_op,
  output logic [DATA_W-1:0] first_input,
  output logic [DATA_W-1:0] second_input,
  output logic [CTRL_W-1:0] alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_illegal,
  output logic              busy,
  output logic              chk_err
);

  localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(4'b0110);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t r_state;
  logic   r_illegal;
  logic   w_req_illegal;

  assign w_req_illegal = !((req_op == OP_AND) || (req_op == OP_OR) ||
                           (req_op == OP_ADD) || (req_op == OP_SUB));

  // Gate with rst_n so the handshake is closed while reset is held.
  assign req_ready = rst_n & (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      first_input  <= '0;
      second_input <= '0;
      alu_control  <= '0;
      r_illegal    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_illegal  <= 1'b0;
      rsp_valid    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            first_input  <= req_a;
            second_input <= req_b;
            alu_control  <= req_op;
            r_illegal    <= w_req_illegal;
            r_state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          rsp_result  <= alu_result;
          rsp_zero    <= zero;
          rsp_illegal <= r_illegal;
          rsp_valid   <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_SELF_CHECK_EN
  logic [DATA_W-1:0] w_exp_result;
  logic              r_chk_err;

  always_comb begin
    w_exp_result = '0;
    case (alu_control)
      OP_AND:  w_exp_result = first_input & second_input;
      OP_OR:   w_exp_result = first_input | second_input;
      OP_ADD:  w_exp_result = first_input + second_input;
      OP_SUB:  w_exp_result = first_input - second_input;
      default: w_exp_result = '0;
    endcase
  end

  // Compared at the same edge the result is captured; illegal ops are skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk_err <= 1'b0;
    end else if ((r_state == S_SETTLE) && !r_illegal) begin
      if ((alu_result != w_exp_result) || (zero != (w_exp_result == '0)))
        r_chk_err <= 1'b1;
    end
  end

  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_op;
  logic [63:0] first_input;
  logic [63:0] second_input;
  logic [3:0]  alu_control;
  logic [63:0] alu_result;
  logic        zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_illegal;
  logic        busy;
  logic        chk_err;
  logic        corrupt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(64), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .first_input(first_input), .second_input(second_input),
    .alu_control(alu_control),
    .alu_result(alu_result), .zero(zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
    .busy(busy), .chk_err(chk_err)
  );

  // Stand-in combinational ALU; corrupt flips bit 0 for checker testing.
  always_comb begin
    logic [63:0] res;
    res = 64'd0;
    case (alu_control)
      4'b0000: res = first_input & second_input;
      4'b0001: res = first_input | second_input;
      4'b0010: res = first_input + second_input;
      4'b0110: res = first_input - second_input;
      default: res = 64'd0;
    endcase
    alu_result = res ^ {63'd0, corrupt};
    zero       = (res == 64'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request from IDLE and waits for the response, then releases it.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                        output logic [63:0] res, output logic zf, output logic ill,
                        output int lat);
    int guard;
    guard = 0;
    while (!req_ready && guard < 10) begin
      tick();
      guard++;
    end
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
    res = rsp_result; zf = rsp_zero; ill = rsp_illegal;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; corrupt = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    #3;
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || chk_err !== 1'b0) begin
      bad++; $display("FAIL reset_flags got valid=%b busy=%b chk=%b want 0", rsp_valid, busy, chk_err);
    end
    total++;
    if (first_input !== 64'd0 || second_input !== 64'd0 || alu_control !== 4'd0 || rsp_result !== 64'd0) begin
      bad++; $display("FAIL reset_regs got a=%h b=%h c=%h r=%h want 0", first_input, second_input, alu_control, rsp_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL idle_req_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_first_op();
    logic [63:0] res; logic zf, ill; int lat;
    run_op(64'hB, 64'hD, 4'b0000, res, zf, ill, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL first_latency got=%0d want=2", lat); end
    total++;
    if (res !== 64'h9 || zf !== 1'b0 || ill !== 1'b0) begin
      bad++; $display("FAIL first_and got r=%h z=%b i=%b want r=9 z=0 i=0", res, zf, ill);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] va [3] = '{64'h9, 64'h6, 64'h7};
    logic [63:0] vb [3] = '{64'hC, 64'h5, 64'h3};
    logic [3:0]  vo [3] = '{4'b0001, 4'b0010, 4'b0110};
    logic [63:0] ve [3] = '{64'hD, 64'hB, 64'h4};
    rsp_ready = 1'b1;
    req_a = va[0]; req_b = vb[0]; req_op = vo[0]; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle_ready[%0d] got=%b want=1", i, req_ready); end
      tick();  // E0
      total++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL b2b_settle[%0d] got ready=%b busy=%b want 0/1", i, req_ready, busy);
      end
      tick();  // E1
      total++;
      if (rsp_valid !== 1'b1 || rsp_result !== ve[i] || req_ready !== 1'b0) begin
        bad++; $display("FAIL b2b_resp[%0d] got v=%b r=%h rdy=%b want v=1 r=%h rdy=0", i, rsp_valid, rsp_result, req_ready, ve[i]);
      end
      // Offer the next request while the response is being consumed.
      if (i < 2) begin
        req_a = va[i+1]; req_b = vb[i+1]; req_op = vo[i+1];
      end else begin
        req_valid = 1'b0;
      end
      tick();  // E2
      total++;
      if (rsp_valid !== 1'b0 || first_input !== va[i]) begin
        bad++; $display("FAIL b2b_release[%0d] got v=%b a=%h want v=0 a=%h", i, rsp_valid, first_input, va[i]);
      end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_sub_edges();
    logic [63:0] res; logic zf, ill; int lat;
    run_op(64'h7, 64'h7, 4'b0110, res, zf, ill, lat);
    total++;
    if (res !== 64'd0 || zf !== 1'b1) begin bad++; $display("FAIL sub_zero got r=%h z=%b want r=0 z=1", res, zf); end
    run_op(64'h0, 64'h1, 4'b0110, res, zf, ill, lat);
    total++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF || zf !== 1'b0) begin
      bad++; $display("FAIL sub_wrap got r=%h z=%b want r=ffffffffffffffff z=0", res, zf);
    end
    total++;
    if (first_input !== 64'h0 || second_input !== 64'h1 || alu_control !== 4'b0110) begin
      bad++; $display("FAIL hold_regs got a=%h b=%h c=%h want 0/1/6", first_input, second_input, alu_control);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_a = 64'hB; req_b = 64'h4; req_op = 4'b0000; req_valid = 1'b1;
    tick();
    req_a = 64'h1; req_b = 64'h1; req_op = 4'b0001;  // stays pending
    tick();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_result !== 64'h0 || first_input !== 64'hB || req_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d] got v=%b r=%h a=%h rdy=%b want v=1 r=0 a=b rdy=0", i, rsp_valid, rsp_result, first_input, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_release got v=%b busy=%b want 0/0", rsp_valid, busy);
    end
    tick();
    req_valid = 1'b0;
    total++;
    if (first_input !== 64'h1 || alu_control !== 4'b0001) begin
      bad++; $display("FAIL bp_pending_accept got a=%h c=%h want 1/1", first_input, alu_control);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_result !== 64'h1) begin
      bad++; $display("FAIL bp_pending_resp got v=%b r=%h want 1/1", rsp_valid, rsp_result);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_illegal();
    req_a = 64'h1; req_b = 64'h2; req_op = 4'b1111; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    total++;
    if (alu_control !== 4'b1111) begin bad++; $display("FAIL illegal_drive got c=%b want 1111", alu_control); end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1 || chk_err !== 1'b0) begin
      bad++; $display("FAIL illegal_resp got v=%b i=%b chk=%b want 1/1/0", rsp_valid, rsp_illegal, chk_err);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_a = 64'h5; req_b = 64'h3; req_op = 4'b0010; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_settle got busy=%b want 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0 ||
        first_input !== 64'd0 || second_input !== 64'd0 || alu_control !== 4'd0) begin
      bad++; $display("FAIL mid_async got v=%b busy=%b rdy=%b a=%h b=%h c=%h want all 0",
                      rsp_valid, busy, req_ready, first_input, second_input, alu_control);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL mid_no_resp[%0d] got v=%b busy=%b want 0/0", i, rsp_valid, busy);
      end
    end
    rsp_ready = 1'b0;
  endtask

`ifdef ALU_SEQ_SELF_CHECK_EN
  task automatic test_self_check();
    logic [63:0] res; logic zf, ill; int lat;
    total++;
    if (chk_err !== 1'b0) begin bad++; $display("FAIL chk_clean got=%b want=0", chk_err); end
    corrupt = 1'b1;
    run_op(64'h3, 64'h4, 4'b0010, res, zf, ill, lat);
    corrupt = 1'b0;
    total++;
    if (chk_err !== 1'b1) begin bad++; $display("FAIL chk_set got=%b want=1", chk_err); end
    run_op(64'h3, 64'h4, 4'b0010, res, zf, ill, lat);
    total++;
    if (chk_err !== 1'b1 || res !== 64'h7) begin
      bad++; $display("FAIL chk_sticky got chk=%b r=%h want 1/7", chk_err, res);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_op();
    test_back_to_back();
    test_sub_edges();
    test_backpressure();
    test_illegal();
    test_reset_mid();
`ifdef ALU_SEQ_SELF_CHECK_EN
    test_self_check();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
